instr_fetch_seq: RTL

//  Instruction fetch/issue sequencer for the 8-bit RISC core; the initiator that feeds the per-instruction address latch.

---
 rtl/cpu_isa_pkg.sv | 38 +++
 rtl/instr_hold_counter.sv | 27 ++
 rtl/instr_fetch_seq.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit RISC core: opcodes, execute hold lengths
// and the fetch sequencer state encoding.
package cpu_isa_pkg;

  localparam int ISA_OP_W = 3;
  localparam int HOLD_W   = 3;

  localparam logic [ISA_OP_W-1:0] OP_HLT = 3'd0;
  localparam logic [ISA_OP_W-1:0] OP_SKZ = 3'd1;
  localparam logic [ISA_OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [ISA_OP_W-1:0] OP_AND = 3'd3;
  localparam logic [ISA_OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [ISA_OP_W-1:0] OP_LDA = 3'd5;
  localparam logic [ISA_OP_W-1:0] OP_STO = 3'd6;
  localparam logic [ISA_OP_W-1:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } fsm_state_t;

  // Number of EXEC cycles following DECODE; HLT never enters EXEC.
  function automatic logic [HOLD_W-1:0] hold_cycles(input logic [ISA_OP_W-1:0] opcode);
    logic [HOLD_W-1:0] n;
    case (opcode)
      OP_HLT:  n = 3'd0;
      OP_SKZ:  n = 3'd3;
      OP_STO:  n = 3'd4;
      OP_JMP:  n = 3'd3;
      default: n = 3'd5;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/instr_hold_counter.sv
// Execute-phase hold counter: loaded in DECODE, counts down to zero and flags
// the final EXEC cycle (count == 1).
module instr_hold_counter
  import cpu_isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  output logic              last
);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == HOLD_W'(1));

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/issue sequencer: owns the PC, fetches one instruction byte,
// issues opcode/address downstream and holds for the opcode's execute length.
module instr_fetch_seq
  import cpu_isa_pkg::*;
#(
  parameter int              PC_W     = 5,
  parameter int              OP_W     = 3,
  parameter int              DATA_W   = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              zero_in,
  input  logic              go,
  output logic              mem_rd,
  output logic [PC_W-1:0]   mem_addr,
  output logic              op_valid,
  output logic [OP_W-1:0]   op_code,
  output logic [PC_W-1:0]   op_addr,
  output logic              busy,
  output logic              halted
);

  fsm_state_t      state;
  fsm_state_t      state_nxt;
  logic [PC_W-1:0] pc;
  logic [OP_W-1:0] dec_op;
  logic [PC_W-1:0] dec_addr;
  logic            hold_last;

  // mem_rdata is only meaningful in DECODE (synchronous read issued in FETCH).
  assign dec_op   = mem_rdata[DATA_W-1 -: OP_W];
  assign dec_addr = mem_rdata[PC_W-1:0];
  assign mem_addr = pc;

  instr_hold_counter u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_DECODE),
    .load_val (hold_cycles(dec_op)),
    .last     (hold_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = (dec_op == OP_HLT) ? ST_HALT : ST_EXEC;
      ST_EXEC:   if (hold_last) state_nxt = ST_FETCH;
      ST_HALT:   if (go) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= START_PC;
      mem_rd   <= 1'b0;
      op_valid <= 1'b0;
      op_code  <= '0;
      op_addr  <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_rd   <= (state_nxt == ST_FETCH);
      busy     <= (state_nxt == ST_FETCH) || (state_nxt == ST_DECODE) || (state_nxt == ST_EXEC);
      halted   <= (state_nxt == ST_HALT);
      op_valid <= 1'b0;
      if (state == ST_DECODE) begin
        op_code  <= dec_op;
        op_addr  <= dec_addr;
        op_valid <= 1'b1;
        pc       <= (dec_op == OP_JMP) ? dec_addr : pc + 1'b1;
      end
      // SKZ looks at the flag only on its last EXEC cycle; a set flag skips one instruction.
      if (state == ST_EXEC && hold_last && op_code == OP_SKZ && zero_in) begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule
